// File: rtl/ql_cc_pipe_adder_pkg.sv
// Shared definitions for the segmented carry-chain adder: default geometry,
// segment-count helpers and the per-segment pipeline payload.
package ql_cc_pkg;

    localparam int CC_WIDTH = 32;
    localparam int CC_SEG_W = 8;

    function automatic int nseg_calc(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    function automatic bit seg_cfg_ok(input int width, input int seg_w);
        return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

    // One segment's worth of payload: propagate/generate before the segment
    // is resolved, sum and carries after.
    typedef struct packed {
        logic [CC_SEG_W-1:0] p;
        logic [CC_SEG_W-1:0] g;
        logic [CC_SEG_W-1:0] sum;
        logic                ci;
        logic                co;
    } cc_seg_t;

endpackage

// File: rtl/ql_cc_pipe_adder_if.sv
// Operand/result valid-ready stream bundle for ql_cc_pipe_adder.
interface ql_cc_pipe_adder_if
    import ql_cc_pkg::*;
#(
    parameter int WIDTH = CC_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, ci, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, ci, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );

endinterface

// File: rtl/ql_cc_pipe_adder_segment.sv
// SEG_W-bit combinational ripple of the XOR/MUX2 carry cell:
// SUMOUT = P ^ CI, CO = P ? CI : G.
module ql_cc_segment
    import ql_cc_pkg::*;
#(
    parameter int SEG_W = CC_SEG_W
) (
    input  logic [SEG_W-1:0] p,
    input  logic [SEG_W-1:0] g,
    input  logic             ci,
    output logic [SEG_W-1:0] sum,
    output logic             co,
    output logic             c_msb_in
);

    logic carry;

    // Carry is walked as a procedural variable so the ripple is one clean
    // combinational chain rather than a self-referencing vector.
    always_comb begin
        carry    = ci;
        sum      = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < SEG_W; i++) begin
            if (i == SEG_W - 1) begin
                c_msb_in = carry;
            end
            sum[i] = p[i] ^ carry;
            carry  = p[i] ? carry : g[i];
        end
        co = carry;
    end

endmodule

// File: rtl/ql_cc_pipe_adder.sv
// Pipelined add/subtract: one carry segment resolved per stage, operands
// skewed ahead of the carry and sums deskewed behind it; latency NSEG.
module ql_cc_pipe_adder
    import ql_cc_pkg::*;
#(
    parameter int WIDTH = CC_WIDTH,
    parameter int SEG_W = CC_SEG_W
) (
    input  logic                clk,
    input  logic                rst,
    ql_cc_pipe_adder_if.slave   bus
);

    localparam int NSEG = nseg_calc(WIDTH, SEG_W);

    if (!seg_cfg_ok(WIDTH, SEG_W) || (SEG_W != CC_SEG_W)) begin : g_bad_cfg
        $error("ql_cc_pipe_adder: WIDTH must be a multiple of SEG_W and SEG_W must equal CC_SEG_W");
    end

    logic rst_meta_q;
    logic rst_sync_q;

    logic            en;
    logic [NSEG-1:0] vld_q;
    cc_seg_t         pipe_q [NSEG][NSEG];
    cc_seg_t         pipe_d [NSEG][NSEG];
    cc_seg_t         in_seg [NSEG];
    logic            ovf_q;
    logic            ovf_d;

    logic [SEG_W-1:0] seg_p    [NSEG];
    logic [SEG_W-1:0] seg_g    [NSEG];
    logic [SEG_W-1:0] seg_sum  [NSEG];
    logic             seg_ci   [NSEG];
    logic             seg_co   [NSEG];
    logic             seg_cmsb [NSEG];

    // Reset asserts immediately, releases two clean edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign en           = ~vld_q[NSEG-1] | bus.out_ready;
    assign bus.in_ready = en;

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
        logic [SEG_W-1:0] a_s;
        logic [SEG_W-1:0] bx_s;

        assign a_s        = bus.a[gi*SEG_W +: SEG_W];
        assign bx_s       = bus.b[gi*SEG_W +: SEG_W] ^ {SEG_W{bus.sub}};
        assign in_seg[gi] = {a_s ^ bx_s, a_s & bx_s, {SEG_W{1'b0}}, 1'b0, 1'b0};

        // Stage gi resolves segment gi; its carry-in is the previous stage's registered CO.
        if (gi == 0) begin : g_first
            assign seg_p[gi]  = in_seg[0].p;
            assign seg_g[gi]  = in_seg[0].g;
            assign seg_ci[gi] = bus.ci ^ bus.sub;
        end else begin : g_rest
            assign seg_p[gi]  = pipe_q[gi-1][gi].p;
            assign seg_g[gi]  = pipe_q[gi-1][gi].g;
            assign seg_ci[gi] = pipe_q[gi-1][gi-1].co;
        end

        ql_cc_segment #(
            .SEG_W (SEG_W)
        ) u_seg (
            .p        (seg_p[gi]),
            .g        (seg_g[gi]),
            .ci       (seg_ci[gi]),
            .sum      (seg_sum[gi]),
            .co       (seg_co[gi]),
            .c_msb_in (seg_cmsb[gi])
        );

        assign bus.sum[gi*SEG_W +: SEG_W] = pipe_q[NSEG-1][gi].sum;
    end

    always_comb begin
        for (int j = 0; j < NSEG; j++) begin
            pipe_d[0][j] = in_seg[j];
        end
        for (int k = 1; k < NSEG; k++) begin
            for (int j = 0; j < NSEG; j++) begin
                pipe_d[k][j] = pipe_q[k-1][j];
            end
        end
        for (int k = 0; k < NSEG; k++) begin
            pipe_d[k][k].sum = seg_sum[k];
            pipe_d[k][k].ci  = seg_ci[k];
            pipe_d[k][k].co  = seg_co[k];
        end
    end

    assign ovf_d = seg_cmsb[NSEG-1] ^ seg_co[NSEG-1];

    // Whole pipe advances together; bubbles travel as valid=0.
    always_ff @(posedge clk or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            vld_q <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                for (int j = 0; j < NSEG; j++) begin
                    pipe_q[k][j] <= '0;
                end
            end
        end else if (en) begin
            vld_q[0] <= bus.in_valid;
            for (int k = 1; k < NSEG; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            pipe_q <= pipe_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.out_valid = vld_q[NSEG-1];
    assign bus.co        = pipe_q[NSEG-1][NSEG-1].co;
    assign bus.ovf       = ovf_q;

    // Already-consumed skew fields and lower-segment MSB carries are folded away here.
    logic unused_bits;
    always_comb begin
        unused_bits = 1'b0;
        for (int k = 0; k < NSEG; k++) begin
            unused_bits = unused_bits ^ seg_cmsb[k];
            for (int j = 0; j < NSEG; j++) begin
                unused_bits = unused_bits ^ (^pipe_q[k][j]);
            end
        end
    end

endmodule

// File: tb/tb_ql_cc_pipe_adder.sv
// Scoreboard bench for ql_cc_pipe_adder: driver pushes model results, monitor pops on each handshake.
module tb_ql_cc_pipe_adder;

    localparam int W  = 32;
    localparam int SW = 8;
    localparam int NS = W / SW;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ql_cc_pipe_adder_if #(.WIDTH(W)) bus ();

    ql_cc_pipe_adder #(
        .WIDTH (W),
        .SEG_W (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   cyc    = 0;
    int   rdy_mode = 1;
    logic tp_mode = 1'b0;
    int   tp_first = 0;
    int   tp_last  = 0;
    int   tp_cnt   = 0;

    // Reference: plain modular arithmetic and the textbook signed-overflow rule.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic ci);
        exp_t         r;
        logic [W-1:0] bo;
        logic [W:0]   full;
        bo    = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, bo} + (W+1)'(ci ^ sub);
        r.sum = full[W-1:0];
        r.co  = full[W];
        r.ovf = (a[W-1] == bo[W-1]) && (r.sum[W-1] != a[W-1]);
        return r;
    endfunction

    always @(posedge clk) cyc++;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: stability while stalled, and in-order compare on every handshake.
    logic         hold_v = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_co;
    logic         hold_ovf;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                if (!(bus.out_valid === 1'b1 && bus.sum === hold_sum &&
                      bus.co === hold_co && bus.ovf === hold_ovf)) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b sum=%h co=%0b ovf=%0b, need v=1 sum=%h co=%0b ovf=%0b",
                             bus.out_valid, bus.sum, bus.co, bus.ovf, hold_sum, hold_co, hold_ovf);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (tp_mode) begin
                    if (tp_cnt == 0) tp_first = cyc;
                    tp_last = cyc;
                    tp_cnt++;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got sum=%h co=%0b ovf=%0b, need no result", bus.sum, bus.co, bus.ovf);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.sum !== mon_e.sum || bus.co !== mon_e.co || bus.ovf !== mon_e.ovf) begin
                        errors++;
                        $display("FAIL result: got sum=%h co=%0b ovf=%0b, need sum=%h co=%0b ovf=%0b",
                                 bus.sum, bus.co, bus.ovf, mon_e.sum, mon_e.co, mon_e.ovf);
                    end else begin
                        $display("beat ok: sum=%h co=%0b ovf=%0b", bus.sum, bus.co, bus.ovf);
                    end
                end
            end
            hold_v   = bus.out_valid && !bus.out_ready;
            hold_sum = bus.sum;
            hold_co  = bus.co;
            hold_ovf = bus.ovf;
        end
    end

    task automatic check1(input string name, input logic [W-1:0] got, input logic [W-1:0] need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("FAIL %s: got %h, need %h", name, got, need);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input exp_t e, input string tag);
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                break;
            end
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout %s: in_ready=0, need 1", tag);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic ci);
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        bus.ci       = ci;
        bus.in_valid = 1'b1;
    endtask

    task automatic send_dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic ci,
                            input logic [W-1:0] s, input logic co, input logic ovf, input string tag);
        exp_t e;
        e.sum = s;
        e.co  = co;
        e.ovf = ovf;
        drive(a, b, sub, ci);
        wait_accept(e, tag);
    endtask

    task automatic send_rand(input string tag);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         ci;
        a   = $urandom;
        b   = $urandom;
        sub = 1'($urandom_range(0, 1));
        ci  = 1'($urandom_range(0, 1));
        drive(a, b, sub, ci);
        wait_accept(model(a, b, sub, ci), tag);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check1({"drain_", tag}, W'(exp_q.size()), W'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic         rc;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.sub      = 1'b0;
        bus.ci       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_out_valid", W'(bus.out_valid), W'(0));
        check1("rst_sum", bus.sum, W'(0));
        check1("rst_co", W'(bus.co), W'(0));
        check1("rst_ovf", W'(bus.ovf), W'(0));
        rst = 1'b0;
        idle(4);
        check1("in_ready_after_rst", W'(bus.in_ready), W'(1));

        // Full-width carry ripple, with latency measured from the accepting edge.
        send_dir(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "carry_ripple");
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        check1("latency", W'(lat), W'(NS));
        idle(1);

        send_dir(32'h5, 32'h7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        send_dir(32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
        send_dir(32'h0000_00FF, 32'h0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, "carry_in");
        send_dir(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
        drain("directed");

        // Back-to-back throughput.
        tp_cnt  = 0;
        tp_mode = 1'b1;
        for (int i = 0; i < 16; i++) send_rand("throughput");
        drain("throughput");
        tp_mode = 1'b0;
        check1("tp_count", W'(tp_cnt), W'(16));
        check1("tp_span", W'(tp_last - tp_first), W'(15));

        // Backpressure with a full pipe.
        rdy_mode = 0;
        for (int i = 0; i < NS; i++) send_rand("bp_fill");
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom_range(0, 1));
        rc = 1'($urandom_range(0, 1));
        drive(ra, rb, rs, rc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("bp_in_ready", W'(bus.in_ready), W'(0));
            check1("bp_out_valid", W'(bus.out_valid), W'(1));
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        wait_accept(model(ra, rb, rs, rc), "bp_release");
        drain("backpressure");

        // Random traffic with random bubbles and random consumer stalls.
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_rand("random");
        end
        rdy_mode = 1;
        drain("random");

        // Reset with the pipe full and stalled: everything in flight is dropped.
        rdy_mode = 0;
        for (int i = 0; i < NS; i++) send_rand("rst_fill");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check1("midrst_out_valid", W'(bus.out_valid), W'(0));
        check1("midrst_sum", bus.sum, W'(0));
        check1("midrst_co", W'(bus.co), W'(0));
        check1("midrst_ovf", W'(bus.ovf), W'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rdy_mode = 1;
        n0 = n_out;
        idle(2);
        rst = 1'b0;
        idle(12);
        check1("no_stale_beats", W'(n_out - n0), W'(0));
        check1("post_rst_in_ready", W'(bus.in_ready), W'(1));

        send_dir(32'h0000_00FF, 32'h0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, "post_rst_carry_in");
        for (int i = 0; i < 8; i++) send_rand("post_rst");
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
